// File: rtl/it_cond_unit.sv
// -----------------------------------------------------------------------------
// it_cond_unit
//
// Holds the Thumb IT execution state (IT[7:0]) and derives the condition that
// applies to the instruction currently retiring.
// IT[7:4] is the base condition of the current instruction.
// IT[4:0] is the shifting mask: the lowest set bit marks the end of the block,
// and bit 4 supplies the low bit of the condition for the current slot.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   rst            in   1  asynchronous active-high reset
//   it_load        in   1  IT instruction decoded this cycle
//   it_firstcond   in   4  IT firstcond field
//   it_mask        in   4  IT mask field
//   inst_valid     in   1  current instruction retires (advances IT state)
//   flags_nzcv     in   4  APSR flags {N,Z,C,V}
//   epsr_wr        in   1  restore IT state (exception return / MSR)
//   epsr_wr_data   in   8  IT[7:0] value to restore
//   it_state       out  8  current IT[7:0], registered
//   in_it_block    out  1  IT[3:0] != 0
//   cur_cond       out  4  condition for the current instruction (AL outside a block)
//   cond_pass      out  1  cur_cond evaluated against flags_nzcv
//   it_last        out  1  current instruction is the last one of the block
//   it_remaining   out  3  instructions left in block, including current
//   it_err         out  1  one-cycle pulse after an ignored load (mask 0000)
//
// Optional feature (macro IT_COND_SKIP_CNT_EN):
//   skip_cnt_clr   in   1  synchronous clear of skip_cnt
//   skip_cnt       out 16  saturating count of in-block retirements that failed
//                          their condition
// -----------------------------------------------------------------------------
module it_cond_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       it_load,
  input  logic [3:0] it_firstcond,
  input  logic [3:0] it_mask,
  input  logic       inst_valid,
  input  logic [3:0] flags_nzcv,
  input  logic       epsr_wr,
  input  logic [7:0] epsr_wr_data,
`ifdef IT_COND_SKIP_CNT_EN
  input  logic        skip_cnt_clr,
  output logic [15:0] skip_cnt,
`endif
  output logic [7:0] it_state,
  output logic       in_it_block,
  output logic [3:0] cur_cond,
  output logic       cond_pass,
  output logic       it_last,
  output logic [2:0] it_remaining,
  output logic       it_err
);

  // Evaluate an ARM condition code against {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  logic [7:0] it_state_r;
  logic [7:0] state_nxt;
  logic       it_err_r;
  logic       err_nxt;

  // Next IT state and error pulse, priority epsr_wr > it_load > advance.
  always_comb begin
    state_nxt = it_state_r;
    err_nxt   = 1'b0;
    if (epsr_wr) begin
      state_nxt = epsr_wr_data;
    end else if (it_load) begin
      if (it_mask != 4'b0000) begin
        state_nxt = {it_firstcond, it_mask};
      end else begin
        err_nxt = 1'b1;
      end
    end else if (inst_valid && in_it_block) begin
      if (it_state_r[2:0] == 3'b000) begin
        // Last instruction of the block just retired.
        state_nxt = 8'h00;
      end else begin
        // Shift IT[4:0] left by one; IT[7:5] holds the base condition.
        state_nxt = {it_state_r[7:5], it_state_r[3:0], 1'b0};
      end
    end else begin
      state_nxt = it_state_r;
    end
  end

  // IT state and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      it_state_r <= 8'h00;
      it_err_r   <= 1'b0;
    end else begin
      it_state_r <= state_nxt;
      it_err_r   <= err_nxt;
    end
  end

  // Decode of the current IT state.
  always_comb begin
    in_it_block = (it_state_r[3:0] != 4'b0000);
    it_last     = (it_state_r[3:0] == 4'b1000);
    if (in_it_block) begin
      cur_cond = it_state_r[7:4];
    end else begin
      cur_cond = 4'b1110;
    end
    cond_pass = eval_cond(cur_cond, flags_nzcv);
    // The lowest set mask bit marks the block end; its position gives the count.
    if (it_state_r[0]) begin
      it_remaining = 3'd4;
    end else if (it_state_r[1]) begin
      it_remaining = 3'd3;
    end else if (it_state_r[2]) begin
      it_remaining = 3'd2;
    end else if (it_state_r[3]) begin
      it_remaining = 3'd1;
    end else begin
      it_remaining = 3'd0;
    end
  end

  assign it_state = it_state_r;
  assign it_err   = it_err_r;

`ifdef IT_COND_SKIP_CNT_EN
  logic [15:0] skip_cnt_r;

  // Saturating count of skipped (condition-failed) in-block retirements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt_r <= 16'h0000;
    end else if (skip_cnt_clr) begin
      skip_cnt_r <= 16'h0000;
    end else if (inst_valid && in_it_block && !cond_pass && (skip_cnt_r != 16'hFFFF)) begin
      skip_cnt_r <= skip_cnt_r + 16'h0001;
    end else begin
      skip_cnt_r <= skip_cnt_r;
    end
  end

  assign skip_cnt = skip_cnt_r;
`endif

endmodule
